// File: rtl/event_pkg.sv
// Shared definitions for the round-robin DVS event scheduler.
//   EVT_W_DEF   default width of the x, y and t event fields
//   pol_mode_e  polarity gate encodings driven on pol_mode
//   state_e     scheduler FSM state encodings
//   pol_pass()  returns 1 when an event of polarity p gets through the gate
package event_pkg;

   localparam int EVT_W_DEF = 16;

   typedef enum logic [1:0] {
      POL_PASS_ALL = 2'b00,
      POL_ON_ONLY  = 2'b01,
      POL_OFF_ONLY = 2'b10,
      POL_DROP_ALL = 2'b11
   } pol_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_DRAIN = 2'b10
   } state_e;

   function automatic logic pol_pass(input logic [1:0] mode, input logic p);
      logic pass;
      case (mode)
         POL_PASS_ALL: pass = 1'b1;
         POL_ON_ONLY:  pass = p;
         POL_OFF_ONLY: pass = ~p;
         default:      pass = 1'b0;
      endcase
      return pass;
   endfunction

endpackage

// File: rtl/event_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req        in   NUM_SRC   request vector
//   ptr        in   IDX_W     highest-priority index for this cycle
//   grant      out  NUM_SRC   one-hot grant (all zero when no request)
//   idx        out  IDX_W     encoded index of the granted request
//   any_grant  out  1         at least one request is present
module rr_arbiter #(
   parameter int NUM_SRC = 4,
   parameter int IDX_W   = $clog2(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_SRC-1:0] grant,
   output logic [IDX_W-1:0]   idx,
   output logic               any_grant
);

   int cand;

   // Walk ptr, ptr+1, ... wrapping; the first requester found wins.
   always_comb begin
      grant     = '0;
      idx       = '0;
      any_grant = 1'b0;
      cand      = 0;
      for (int k = 0; k < NUM_SRC; k++) begin
         cand = (int'(ptr) + k) % NUM_SRC;
         if (!any_grant && req[cand]) begin
            any_grant   = 1'b1;
            grant[cand] = 1'b1;
            idx         = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/event_rr_scheduler.sv
// Round-robin scheduler that shares one event-filter datapath between
// NUM_SRC DVS event sources, with a polarity gate and forward/drop counters.
//   clk, rst            clock and synchronous active-high reset
//   enable              1 accepts events; 0 stops new grants and drains output
//   pol_mode            polarity gate: 00 all, 01 p=1, 10 p=0, 11 none
//   cnt_clr             synchronous clear of both counters (beats increment)
//   s_valid/s_ready     per-source handshake; s_ready is combinational
//   s_x/s_y/s_t/s_p     packed per-source event fields
//   m_valid/m_ready     output handshake, registered output stage
//   m_x/m_y/m_t/m_p     output event fields
//   m_src               index of the source the output event came from
//   fwd_count           saturating count of forwarded events
//   drop_count          saturating count of consumed but gated events
//   busy                FSM is not idle
module event_rr_scheduler
   import event_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int EVT_W   = EVT_W_DEF,
   parameter int CNT_W   = 16,
   parameter int IDX_W   = $clog2(NUM_SRC)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic [1:0]               pol_mode,
   input  logic                     cnt_clr,
   input  logic [NUM_SRC-1:0]       s_valid,
   output logic [NUM_SRC-1:0]       s_ready,
   input  logic [NUM_SRC*EVT_W-1:0] s_x,
   input  logic [NUM_SRC*EVT_W-1:0] s_y,
   input  logic [NUM_SRC*EVT_W-1:0] s_t,
   input  logic [NUM_SRC-1:0]       s_p,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [EVT_W-1:0]         m_x,
   output logic [EVT_W-1:0]         m_y,
   output logic [EVT_W-1:0]         m_t,
   output logic                     m_p,
   output logic [IDX_W-1:0]         m_src,
   output logic [CNT_W-1:0]         fwd_count,
   output logic [CNT_W-1:0]         drop_count,
   output logic                     busy
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   state_e               state, state_nxt;
   logic [IDX_W-1:0]     rr_ptr;
   logic [NUM_SRC-1:0]   grant;
   logic [IDX_W-1:0]     gidx;
   logic                 any_grant;
   logic                 slot_free;
   logic                 accept_ok;
   logic                 accept;
   logic                 pass;
   logic [EVT_W-1:0]     sel_x_p0, sel_y_p0, sel_t_p0;
   logic                 sel_p_p0;

   // ---- stage 0: arbitration, selection and polarity gate ----
   rr_arbiter #(
      .NUM_SRC (NUM_SRC),
      .IDX_W   (IDX_W)
   ) u_arb (
      .req       (s_valid),
      .ptr       (rr_ptr),
      .grant     (grant),
      .idx       (gidx),
      .any_grant (any_grant)
   );

   assign slot_free = ~m_valid | m_ready;
   assign accept_ok = (state == ST_RUN) & enable & slot_free & ~rst;
   assign s_ready   = grant & {NUM_SRC{accept_ok}};
   assign accept    = any_grant & accept_ok;

   assign sel_x_p0  = s_x[int'(gidx)*EVT_W +: EVT_W];
   assign sel_y_p0  = s_y[int'(gidx)*EVT_W +: EVT_W];
   assign sel_t_p0  = s_t[int'(gidx)*EVT_W +: EVT_W];
   assign sel_p_p0  = s_p[gidx];
   assign pass      = pol_pass(pol_mode, sel_p_p0);

   assign busy      = (state != ST_IDLE);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (enable) state_nxt = ST_RUN;
         ST_RUN:   if (!enable) state_nxt = m_valid ? ST_DRAIN : ST_IDLE;
         ST_DRAIN: begin
            if (enable)                   state_nxt = ST_RUN;
            else if (!m_valid || m_ready) state_nxt = ST_IDLE;
         end
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         rr_ptr <= '0;
      end else begin
         state <= state_nxt;
         if (accept)
            rr_ptr <= (gidx == IDX_W'(NUM_SRC-1)) ? '0 : gidx + IDX_W'(1);
      end
   end

   // ---- stage 1: registered output slot ----
   // A gated accept only happens when the slot is free, so clearing valid on
   // m_ready covers both "slot drained" and "nothing accepted" cases.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid <= 1'b0;
         m_x     <= '0;
         m_y     <= '0;
         m_t     <= '0;
         m_p     <= 1'b0;
         m_src   <= '0;
      end else if (accept && pass) begin
         m_valid <= 1'b1;
         m_x     <= sel_x_p0;
         m_y     <= sel_y_p0;
         m_t     <= sel_t_p0;
         m_p     <= sel_p_p0;
         m_src   <= gidx;
      end else if (m_ready) begin
         m_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         fwd_count  <= '0;
         drop_count <= '0;
      end else if (accept) begin
         if (pass) fwd_count  <= sat_inc(fwd_count);
         else      drop_count <= sat_inc(drop_count);
      end
   end

endmodule

// File: tb/tb_event_rr_scheduler.sv
// Directed self-checking bench for event_rr_scheduler (4 sources, 16-bit
// fields, 8-bit counters so saturation is reachable in a short run).
module tb_event_rr_scheduler;

   localparam int NUM_SRC = 4;
   localparam int EVT_W   = 16;
   localparam int CNT_W   = 8;
   localparam int IDX_W   = 2;

   logic                     clk;
   logic                     rst;
   logic                     enable;
   logic [1:0]               pol_mode;
   logic                     cnt_clr;
   logic [NUM_SRC-1:0]       s_valid;
   logic [NUM_SRC-1:0]       s_ready;
   logic [NUM_SRC*EVT_W-1:0] s_x, s_y, s_t;
   logic [NUM_SRC-1:0]       s_p;
   logic                     m_valid;
   logic                     m_ready;
   logic [EVT_W-1:0]         m_x, m_y, m_t;
   logic                     m_p;
   logic [IDX_W-1:0]         m_src;
   logic [CNT_W-1:0]         fwd_count, drop_count;
   logic                     busy;

   int n_chk  = 0;
   int n_fail = 0;

   event_rr_scheduler #(
      .NUM_SRC (NUM_SRC),
      .EVT_W   (EVT_W),
      .CNT_W   (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .pol_mode   (pol_mode),
      .cnt_clr    (cnt_clr),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_x        (s_x),
      .s_y        (s_y),
      .s_t        (s_t),
      .s_p        (s_p),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_x        (m_x),
      .m_y        (m_y),
      .m_t        (m_t),
      .m_p        (m_p),
      .m_src      (m_src),
      .fwd_count  (fwd_count),
      .drop_count (drop_count),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int i, input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] t, input logic p);
      s_x[i*EVT_W +: EVT_W] = x;
      s_y[i*EVT_W +: EVT_W] = y;
      s_t[i*EVT_W +: EVT_W] = t;
      s_p[i]                = p;
   endtask

   int exp_src [8] = '{2, 3, 0, 1, 2, 3, 0, 1};

   initial begin
      rst = 1'b1; enable = 1'b0; pol_mode = 2'b00; cnt_clr = 1'b0;
      s_valid = '0; s_x = '0; s_y = '0; s_t = '0; s_p = '0; m_ready = 1'b0;
      step(); step();
      check("rst_m_valid", m_valid, 0);
      check("rst_m_x", m_x, 0);
      check("rst_m_src", m_src, 0);
      check("rst_fwd", fwd_count, 0);
      check("rst_drop", drop_count, 0);
      check("rst_busy", busy, 0);
      check("rst_s_ready", s_ready, 0);

      // enable: IDLE -> RUN
      rst = 1'b0; enable = 1'b1; m_ready = 1'b1;
      step();
      check("run_busy", busy, 1);

      // single event from source 1
      set_src(1, 16'd5, 16'd7, 16'd100, 1'b1);
      s_valid = 4'b0010;
      #1 check("single_s_ready", s_ready, 4'b0010);
      step();
      s_valid = '0;
      check("single_m_valid", m_valid, 1);
      check("single_m_src", m_src, 1);
      check("single_m_x", m_x, 5);
      check("single_m_y", m_y, 7);
      check("single_m_t", m_t, 100);
      check("single_m_p", m_p, 1);
      check("single_fwd", fwd_count, 1);
      step();
      check("single_drained", m_valid, 0);
      check("single_hold_x", m_x, 5);

      // all four sources continuously valid; pointer now at 2
      for (int i = 0; i < NUM_SRC; i++) set_src(i, 16'h10 + 16'(i), 16'h20 + 16'(i), 16'h30 + 16'(i), 1'b0);
      s_valid = 4'b1111;
      #1 check("rr_first_ready", s_ready, 4'b0100);
      for (int k = 0; k < 8; k++) begin
         step();
         check("rr_m_valid", m_valid, 1);
         check("rr_m_src", m_src, exp_src[k]);
         check("rr_m_x", m_x, 32'h10 + exp_src[k]);
      end
      s_valid = '0;
      step();
      check("rr_fwd", fwd_count, 9);
      check("rr_idle_out", m_valid, 0);

      // mode 01: p=0 dropped, p=1 forwarded
      pol_mode = 2'b01;
      set_src(0, 16'h33, 16'h0, 16'h0, 1'b0);
      s_valid = 4'b0001;
      step();
      check("gate_drop", drop_count, 1);
      check("gate_m_valid0", m_valid, 0);
      check("gate_fwd_same", fwd_count, 9);
      set_src(0, 16'h44, 16'h0, 16'h0, 1'b1);
      step();
      s_valid = '0;
      pol_mode = 2'b00;
      check("gate_pass_valid", m_valid, 1);
      check("gate_pass_src", m_src, 0);
      check("gate_pass_x", m_x, 16'h44);
      check("gate_fwd", fwd_count, 10);

      // backpressure for 5 cycles; pointer at 1
      m_ready = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) set_src(i, 16'h50 + 16'(i), 16'h0, 16'h0, 1'b1);
      s_valid = 4'b1111;
      #1 check("stall_ready0", s_ready, 0);
      for (int k = 0; k < 5; k++) begin
         step();
         check("stall_valid", m_valid, 1);
         check("stall_x", m_x, 16'h44);
         check("stall_src", m_src, 0);
         check("stall_ready", s_ready, 0);
      end
      m_ready = 1'b1;
      #1 check("release_ready", s_ready, 4'b0010);
      step();
      s_valid = '0;
      check("release_src", m_src, 1);
      check("release_x", m_x, 16'h51);
      check("release_fwd", fwd_count, 11);
      step();
      check("release_drained", m_valid, 0);

      // enable falls while output held
      set_src(3, 16'h77, 16'h0, 16'h0, 1'b1);
      s_valid = 4'b1000;
      m_ready = 1'b0;
      step();
      check("drain_load_src", m_src, 3);
      check("drain_load_valid", m_valid, 1);
      enable = 1'b0;
      s_valid = 4'b1111;
      #1 check("drain_no_ready", s_ready, 0);
      step();
      check("drain_busy", busy, 1);
      check("drain_x", m_x, 16'h77);
      step();
      check("drain_busy2", busy, 1);
      check("drain_valid2", m_valid, 1);
      m_ready = 1'b1;
      step();
      check("drain_idle", busy, 0);
      check("drain_out", m_valid, 0);
      check("drain_fwd", fwd_count, 12);
      step();
      check("idle_no_ready", s_ready, 0);
      check("idle_no_valid", m_valid, 0);

      // saturation of drop_count with mode 11
      enable = 1'b1; pol_mode = 2'b11;
      step();
      for (int k = 0; k < 253; k++) step();
      check("sat_fe", drop_count, 8'hFE);
      step();
      check("sat_ff", drop_count, 8'hFF);
      step(); step();
      check("sat_hold", drop_count, 8'hFF);
      check("sat_no_out", m_valid, 0);
      check("sat_fwd", fwd_count, 12);
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      check("clr_drop", drop_count, 0);
      check("clr_fwd", fwd_count, 0);
      step();
      check("clr_then_drop", drop_count, 1);

      // reset in the middle of a burst
      pol_mode = 2'b00;
      step();
      check("burst_valid", m_valid, 1);
      check("burst_fwd", fwd_count, 1);
      rst = 1'b1;
      #1 check("rst_gate_ready", s_ready, 0);
      step();
      check("mid_rst_valid", m_valid, 0);
      check("mid_rst_fwd", fwd_count, 0);
      check("mid_rst_drop", drop_count, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_x", m_x, 0);
      check("mid_rst_src", m_src, 0);
      rst = 1'b0;
      s_valid = '0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
